// File: rtl/mmio_bus_fabric_if.sv
// Load/store port and slave-side bus bundle for mmio_bus_fabric.
// Modport slave is the fabric's view; modport master is the core plus slave-device side.
interface mmio_bus_fabric_if #(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic                       m_ren;
    logic                       m_wen;
    logic [DATA_W-1:0]          m_rdata;
    logic                       m_ready;
    logic                       m_err;
    logic [N_SLAVES-1:0]        s_sel;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic                       s_wen;
    logic                       s_ren;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;
    logic [N_SLAVES-1:0]        s_ack;

    modport slave (
        input  m_addr, m_wdata, m_ren, m_wen, s_rdata, s_ack,
        output m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_wen, s_ren
    );

    modport master (
        output m_addr, m_wdata, m_ren, m_wen, s_rdata, s_ack,
        input  m_rdata, m_ready, m_err, s_sel, s_addr, s_wdata, s_wen, s_ren
    );
endinterface

// File: rtl/mmio_bus_fabric.sv
// Decodes a load/store request against N base/mask windows and holds it on one slave until ack or timeout.
// Latency: 2 cycles minimum (1 for decode errors), +1 per slave wait state; master stalls until the m_ready pulse.
module mmio_bus_fabric #(
    parameter int                          N_SLAVES = 4,
    parameter int                          ADDR_W   = 32,
    parameter int                          DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
    parameter int                          TIMEOUT  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mmio_bus_fabric_if.slave     bus,
    output logic [ADDR_W-1:0]    o_err_addr,
    output logic [7:0]           o_err_cnt
);
    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic                r_rw, w_rw_nxt;
    logic [7:0]          r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_ready, w_ready_nxt;
    logic                r_err, w_err_nxt;
    logic [N_SLAVES-1:0] r_sel, w_sel_nxt;
    logic                r_ren, w_ren_nxt;
    logic                r_wen, w_wen_nxt;
    logic [ADDR_W-1:0]   r_err_addr, w_err_addr_nxt;
    logic [7:0]          r_err_cnt, w_err_cnt_nxt;

    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic                w_ack;
    logic [DATA_W-1:0]   w_slv_rdata;
    logic [7:0]          w_err_cnt_inc;

    // Scan high to low so the lowest matching window is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_ack       = 1'b0;
        w_slv_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_ack       = bus.s_ack[i];
                w_slv_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_err_cnt_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_rw_nxt       = r_rw;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_rdata_nxt    = '0;
        w_ready_nxt    = 1'b0;
        w_err_nxt      = 1'b0;
        w_sel_nxt      = '0;
        w_ren_nxt      = 1'b0;
        w_wen_nxt      = 1'b0;
        w_err_addr_nxt = r_err_addr;
        w_err_cnt_nxt  = r_err_cnt;
        unique case (r_state)
            IDLE: begin
                if ((bus.m_ren ^ bus.m_wen) && w_hit) begin
                    w_state_nxt            = ACCESS;
                    w_idx_nxt              = w_hit_idx;
                    w_rw_nxt               = bus.m_wen;
                    w_cnt_nxt              = 8'd0;
                    w_addr_nxt             = bus.m_addr;
                    w_wdata_nxt            = bus.m_wdata;
                    w_sel_nxt[w_hit_idx]   = 1'b1;
                    w_ren_nxt              = bus.m_ren;
                    w_wen_nxt              = bus.m_wen;
                end else if (bus.m_ren || bus.m_wen) begin
                    w_state_nxt    = RESP;
                    w_ready_nxt    = 1'b1;
                    w_err_nxt      = 1'b1;
                    w_err_addr_nxt = bus.m_addr;
                    w_err_cnt_nxt  = w_err_cnt_inc;
                end
            end
            ACCESS: begin
                if (w_ack) begin
                    w_state_nxt = RESP;
                    w_ready_nxt = 1'b1;
                    w_rdata_nxt = r_rw ? '0 : w_slv_rdata;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_state_nxt    = RESP;
                    w_ready_nxt    = 1'b1;
                    w_err_nxt      = 1'b1;
                    w_err_addr_nxt = r_addr;
                    w_err_cnt_nxt  = w_err_cnt_inc;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    w_sel_nxt = r_sel;
                    w_ren_nxt = r_ren;
                    w_wen_nxt = r_wen;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_rw       <= 1'b0;
            r_cnt      <= 8'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_sel      <= '0;
            r_ren      <= 1'b0;
            r_wen      <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_rw       <= w_rw_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rdata    <= w_rdata_nxt;
            r_ready    <= w_ready_nxt;
            r_err      <= w_err_nxt;
            r_sel      <= w_sel_nxt;
            r_ren      <= w_ren_nxt;
            r_wen      <= w_wen_nxt;
            r_err_addr <= w_err_addr_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    assign bus.m_rdata = r_rdata;
    assign bus.m_ready = r_ready;
    assign bus.m_err   = r_err;
    assign bus.s_sel   = r_sel;
    assign bus.s_addr  = r_addr;
    assign bus.s_wdata = r_wdata;
    assign bus.s_ren   = r_ren;
    assign bus.s_wen   = r_wen;
    assign o_err_addr  = r_err_addr;
    assign o_err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed bench for mmio_bus_fabric: three windows, TIMEOUT of 8.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_mmio_bus_fabric;
    localparam int N = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [N*AW-1:0] BASES = {32'hA000_0000, 32'h9000_0000, 32'h8000_0000};
    localparam logic [N*AW-1:0] MASKS = {32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_FF00};

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_cnt;
    int            tests;
    int            fails;

    mmio_bus_fabric_if #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mmio_bus_fabric #(
        .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
        .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT(8)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus),
        .o_err_addr(err_addr),
        .o_err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        bus.m_addr = '0; bus.m_wdata = '0; bus.m_ren = 1'b0; bus.m_wen = 1'b0;
        bus.s_rdata = '0; bus.s_ack = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus.m_ready, bus.m_err, bus.s_sel, bus.s_ren, bus.s_wen} !== 7'b0) begin
            fails++; $display("FAIL reset_ctl got=%b exp=0", {bus.m_ready, bus.m_err, bus.s_sel, bus.s_ren, bus.s_wen});
        end
        tests++;
        if ({bus.m_rdata, bus.s_addr, bus.s_wdata, err_addr, err_cnt} !== '0) begin
            fails++; $display("FAIL reset_data rdata=%h saddr=%h swdata=%h eaddr=%h ecnt=%0d exp all 0",
                              bus.m_rdata, bus.s_addr, bus.s_wdata, err_addr, err_cnt);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_mapped_read();
        bus.m_addr = 32'h9000_0010; bus.m_ren = 1'b1;
        bus.s_rdata = {32'h0, 32'hDEAD_BEEF, 32'h0}; bus.s_ack = 3'b010;
        @(posedge clk); @(negedge clk);
        tests++;
        if (bus.s_sel !== 3'b010 || bus.s_ren !== 1'b1 || bus.m_ready !== 1'b0) begin
            fails++; $display("FAIL rd_sel sel=%b ren=%b ready=%b exp 010/1/0", bus.s_sel, bus.s_ren, bus.m_ready);
        end
        tests++;
        if (bus.s_addr !== 32'h9000_0010) begin
            fails++; $display("FAIL rd_saddr got=%h exp=90000010", bus.s_addr);
        end
        @(posedge clk); #1 bus.m_ren = 1'b0; bus.s_ack = '0;
        @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'hDEAD_BEEF || bus.s_sel !== 3'b000) begin
            fails++; $display("FAIL rd_resp ready=%b err=%b rdata=%h sel=%b exp 1/0/deadbeef/000",
                              bus.m_ready, bus.m_err, bus.m_rdata, bus.s_sel);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b0 || bus.m_rdata !== 32'h0) begin
            fails++; $display("FAIL rd_after ready=%b rdata=%h exp 0/0", bus.m_ready, bus.m_rdata);
        end
    endtask

    task automatic test_back_to_back();
        bus.m_addr = 32'h9000_0004; bus.m_ren = 1'b1;
        bus.s_rdata = {32'h0, 32'h1111_2222, 32'h0}; bus.s_ack = 3'b010;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); @(negedge clk);
            tests++;
            if (bus.m_ready !== ((c == 2) || (c == 5))) begin
                fails++; $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", c, bus.m_ready, (c == 2) || (c == 5));
            end
        end
        bus.m_ren = 1'b0; bus.s_ack = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write_wait();
        bus.m_addr = 32'hA000_0F04; bus.m_wdata = 32'h1234_5678; bus.m_wen = 1'b1;
        bus.s_rdata = {32'hCAFE_F00D, 32'h0, 32'h0}; bus.s_ack = '0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin bus.m_addr = 32'h8000_0000; bus.m_wdata = 32'hFFFF_FFFF; end
            if (c == 4) bus.s_ack = 3'b100;
            @(negedge clk);
            tests++;
            if (bus.s_wen !== 1'b1 || bus.s_ren !== 1'b0 || bus.s_sel !== 3'b100 || bus.m_ready !== 1'b0 ||
                bus.s_wdata !== 32'h1234_5678 || bus.s_addr !== 32'hA000_0F04) begin
                fails++; $display("FAIL wr_hold cycle=%0d wen=%b ren=%b sel=%b ready=%b wdata=%h addr=%h",
                                  c, bus.s_wen, bus.s_ren, bus.s_sel, bus.m_ready, bus.s_wdata, bus.s_addr);
            end
        end
        @(posedge clk); #1 bus.m_wen = 1'b0; bus.s_ack = '0;
        @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'h0 || bus.s_wen !== 1'b0) begin
            fails++; $display("FAIL wr_resp ready=%b err=%b rdata=%h wen=%b exp 1/0/0/0",
                              bus.m_ready, bus.m_err, bus.m_rdata, bus.s_wen);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unmapped();
        bus.m_addr = 32'h7000_0000; bus.m_ren = 1'b1;
        @(posedge clk); #1 bus.m_ren = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b1 || bus.s_sel !== 3'b000 || bus.m_rdata !== 32'h0) begin
            fails++; $display("FAIL unmap_resp ready=%b err=%b sel=%b rdata=%h exp 1/1/000/0",
                              bus.m_ready, bus.m_err, bus.s_sel, bus.m_rdata);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (err_addr !== 32'h7000_0000 || err_cnt !== 8'd1 || bus.s_sel !== 3'b000) begin
            fails++; $display("FAIL unmap_log eaddr=%h ecnt=%0d sel=%b exp 70000000/1/000", err_addr, err_cnt, bus.s_sel);
        end
        #1;
    endtask

    task automatic test_both_strobes();
        bus.m_addr = 32'h9000_0000; bus.m_ren = 1'b1; bus.m_wen = 1'b1;
        @(posedge clk); #1 bus.m_ren = 1'b0; bus.m_wen = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b1 || bus.s_sel !== 3'b000 || bus.s_ren !== 1'b0 || bus.s_wen !== 1'b0) begin
            fails++; $display("FAIL both_resp ready=%b err=%b sel=%b ren=%b wen=%b exp 1/1/000/0/0",
                              bus.m_ready, bus.m_err, bus.s_sel, bus.s_ren, bus.s_wen);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (err_addr !== 32'h9000_0000 || err_cnt !== 8'd2) begin
            fails++; $display("FAIL both_log eaddr=%h ecnt=%0d exp 90000000/2", err_addr, err_cnt);
        end
        #1;
    endtask

    task automatic test_timeout();
        bus.m_addr = 32'h8000_0000; bus.m_ren = 1'b1;
        bus.s_rdata = {32'h0, 32'h0, 32'h5555_5555}; bus.s_ack = 3'b010;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); @(negedge clk);
            tests++;
            if (bus.s_sel !== 3'b001 || bus.m_ready !== 1'b0) begin
                fails++; $display("FAIL tmo_hold cycle=%0d sel=%b ready=%b exp 001/0", c, bus.s_sel, bus.m_ready);
            end
        end
        @(posedge clk); #1 bus.m_ren = 1'b0; bus.s_ack = '0;
        @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b1 || bus.s_sel !== 3'b000 || bus.m_rdata !== 32'h0) begin
            fails++; $display("FAIL tmo_resp ready=%b err=%b sel=%b rdata=%h exp 1/1/000/0",
                              bus.m_ready, bus.m_err, bus.s_sel, bus.m_rdata);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (err_addr !== 32'h8000_0000 || err_cnt !== 8'd3) begin
            fails++; $display("FAIL tmo_log eaddr=%h ecnt=%0d exp 80000000/3", err_addr, err_cnt);
        end
        #1;
    endtask

    task automatic test_err_saturate();
        // A held unmapped request errors every other cycle: 300 more errors on top of 3.
        bus.m_addr = 32'h7000_1234; bus.m_ren = 1'b1;
        repeat (600) @(posedge clk);
        #1 bus.m_ren = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (err_cnt !== 8'd255 || err_addr !== 32'h7000_1234) begin
            fails++; $display("FAIL sat_cnt ecnt=%0d eaddr=%h exp 255/70001234", err_cnt, err_addr);
        end
        #1;
    endtask

    task automatic test_ack_at_limit();
        bus.m_addr = 32'h8000_0040; bus.m_ren = 1'b1;
        bus.s_rdata = {32'h0, 32'h0, 32'h55AA_55AA}; bus.s_ack = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 8) bus.s_ack = 3'b001;
        end
        @(posedge clk); #1 bus.m_ren = 1'b0; bus.s_ack = '0;
        @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'h55AA_55AA) begin
            fails++; $display("FAIL limit_resp ready=%b err=%b rdata=%h exp 1/0/55aa55aa",
                              bus.m_ready, bus.m_err, bus.m_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        bus.m_addr = 32'h8000_0000; bus.m_ren = 1'b1; bus.s_ack = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.s_sel !== 3'b001) begin
            fails++; $display("FAIL rst_sync sel=%b exp 001", bus.s_sel);
        end
        @(posedge clk); #1 rst_n = 1'b1; bus.m_ren = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.s_sel !== 3'b000 || bus.m_ready !== 1'b0 || err_cnt !== 8'd0 || err_addr !== 32'h0) begin
            fails++; $display("FAIL rst_mid sel=%b ready=%b ecnt=%0d eaddr=%h exp 000/0/0/0",
                              bus.s_sel, bus.m_ready, err_cnt, err_addr);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b0 || bus.s_sel !== 3'b000) begin
            fails++; $display("FAIL rst_idle ready=%b sel=%b exp 0/000", bus.m_ready, bus.s_sel);
        end
        #1 bus.m_addr = 32'h9000_0020; bus.m_ren = 1'b1;
        bus.s_rdata = {32'h0, 32'h0BAD_F00D, 32'h0}; bus.s_ack = 3'b010;
        @(posedge clk); @(posedge clk); #1 bus.m_ren = 1'b0; bus.s_ack = '0;
        @(negedge clk);
        tests++;
        if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'h0BAD_F00D) begin
            fails++; $display("FAIL rst_fresh ready=%b err=%b rdata=%h exp 1/0/0badf00d",
                              bus.m_ready, bus.m_err, bus.m_rdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mapped_read();
        test_back_to_back();
        test_write_wait();
        test_unmapped();
        test_both_strobes();
        test_timeout();
        test_err_saturate();
        test_ack_at_limit();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_bus_fabric.md
# mmio_bus_fabric

Parametrised data-side interconnect between the core's load/store port and N memory-mapped slaves. It replaces fixed per-slave address compare and read-data muxing with a registered transaction engine. Each request is decoded against N base/mask windows, forwarded to one slave, and held until that slave acknowledges. The master sees a one-cycle ready pulse carrying the read data, or an error if the address is unmapped or the slave times out. The block sits between `core` (address/write_data/read_data_sig/write_data_sig) and the RAM, dual-port RAM and peripheral blocks.

## Interface
- `N_SLAVES`, default 4: number of slave windows (1..16).
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `SLV_BASE`, default all-zero, N_SLAVES*ADDR_W bits: packed window bases; slave i uses bits [i*ADDR_W +: ADDR_W].
- `SLV_MASK`, default all-zero, N_SLAVES*ADDR_W bits: packed window masks, same packing as `SLV_BASE`.
- `TIMEOUT`, default 16: maximum cycles in ACCESS before a bus error is raised (2..255).

- `clk`  in  1  single clock; everything is on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `m_addr`  in  ADDR_W  master address.
- `m_wdata`  in  DATA_W  master write data.
- `m_ren`  in  1  master read request.
- `m_wen`  in  1  master write request.
- `m_rdata`  out  DATA_W  read data; valid only when `m_ready`=1.
- `m_ready`  out  1  one-cycle transaction-complete pulse.
- `m_err`  out  1  bus error; qualified by `m_ready`.
- `s_sel`  out  N_SLAVES  one-hot slave select.
- `s_addr`  out  ADDR_W  latched address.
- `s_wdata`  out  DATA_W  latched write data.
- `s_wen`  out  1  write strobe to the selected slave.
- `s_ren`  out  1  read strobe to the selected slave.
- `s_rdata`  in  N_SLAVES*DATA_W  packed slave read data.
- `s_ack`  in  N_SLAVES  per-slave acknowledge.
- `err_addr`  out  ADDR_W  address of the most recent errored transaction.
- `err_cnt`  out  8  saturating count of bus errors.

## Operation
- FSM has three states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - If exactly one of `m_ren`/`m_wen` is high, decode: slave i hits when (m_addr & MASK_i) == BASE_i. The lowest index wins on overlapping windows.
  - On a hit, latch addr, wdata, rw and index into `s_*` registers, clear the timeout counter, go to ACCESS.
  - On a miss, or with `m_ren` and `m_wen` both high, go to RESP with the error flag set. No slave is selected.
  - With neither request high, stay in IDLE.
- **ACCESS**
  - `s_sel[idx]` = 1 and `s_ren`/`s_wen` per the latched rw; all are held stable.
  - When `s_ack[idx]`=1, capture the `s_rdata` slice idx into the rdata register (reads only; writes capture 0), clear err, go to RESP.
  - `s_ack` bits of non-selected slaves are ignored.
  - Otherwise increment the counter. When counter == TIMEOUT-1 with no ack, set err and go to RESP.
  - Master inputs are ignored while in ACCESS.
- **RESP**
  - `m_ready`=1 for exactly one cycle, with `m_rdata`/`m_err` driven from registers. All `s_sel`/`s_ren`/`s_wen` are 0.
  - Always go to IDLE next.
  - If err is set: `err_addr` ← latched addr (the raw `m_addr` for decode misses), and `err_cnt` += 1, saturating at 255.
- `m_rdata` = 0 whenever `m_err`=1 or `m_ready`=0.
- The master holds its request until `m_ready`. A request still asserted in the IDLE cycle after RESP starts a new transaction; the master must drop its request in the RESP cycle to avoid a repeat.

## Timing
- All outputs are registered. Reset values: state IDLE; `m_ready`=0, `m_err`=0, `m_rdata`=0; `s_sel`=0, `s_ren`=0, `s_wen`=0; `s_addr`=0, `s_wdata`=0; `err_addr`=0, `err_cnt`=0.
- Mapped access, request sampled at edge 0:
  - `s_sel` is high in cycle 1.
  - An ack in cycle 1 gives `m_ready` in cycle 2.
  - Minimum latency is 2 cycles; throughput is one transaction per 3 cycles.
- Slave wait states: each cycle of delayed ack adds one cycle of latency.
- Timeout: `s_sel` is high for exactly TIMEOUT cycles, and `m_ready`+`m_err` appear in the following cycle.
- Unmapped or both-strobe request: `m_ready`=1, `m_err`=1 in cycle 1; `s_sel` never asserts.
- Ack in the same cycle the counter reaches TIMEOUT-1: ack wins, no error.
- `rst_n` low in any state: at that edge, go to IDLE and drop all outputs to their reset values, including `err_cnt`; an in-flight transaction is abandoned with no `m_ready`.

## Test plan
- **Mapped read.** N=3; windows 0x8000_0000/0xFFFF_FF00, 0x9000_0000/0xFFFF_FF00, 0xA000_0000/0xFFFF_F000; TIMEOUT=8. Read 0x9000_0010 with slave 1 acking immediately and data 0xDEAD_BEEF -> `s_sel`=3'b010 in cycle 1; `m_ready`=1, `m_rdata`=0xDEAD_BEEF, `m_err`=0 in cycle 2.
- **Write with wait states.** Write 0xA000_0F04 with data 0x1234_5678; slave 2 acks after 3 cycles -> `s_wen`=1 and `s_wdata`=0x1234_5678 held 4 cycles; `m_ready` in cycle 5 with `m_rdata`=0.
- **Unmapped address.** Read 0x7000_0000 -> `m_ready`=1, `m_err`=1 in cycle 1; `s_sel` stays 0; `err_addr`=0x7000_0000; `err_cnt`=1.
- **Timeout.** Read 0x8000_0000 with slave 0 never acking -> `s_sel`=3'b001 for 8 cycles, then `m_ready`+`m_err`. After 300 such errors, `err_cnt`=255.
- **Both strobes.** `m_ren` and `m_wen` both high -> error response; no slave selected.
- **Mid-transaction reset.** Drive `rst_n`=0 in cycle 3 of a stalled access -> next cycle `s_sel`=0, `m_ready`=0, `err_cnt`=0. A fresh read completes normally afterward.
